// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per clock, signed or unsigned, with flush and held results.
//
// state | meaning
// IDLE  | waiting for a start; held results stay on the outputs
// RUN   | iterating, one partial product or quotient bit per cycle
// DONE  | results valid for exactly one cycle (data_resultRDY high)
module multdiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             ctrl_SIGNED,
   input  logic             ctrl_flush,
   output logic [WIDTH-1:0] data_result,
   output logic [WIDTH-1:0] data_high,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic             op_signed;
   logic             neg_q;
   logic             neg_r;
   logic             div_zero;
   logic             div_ovf;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] dividend;

   logic               start;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   mul_hi_n;
   logic [WIDTH-1:0]   mul_lo_n;
   logic [WIDTH-1:0]   div_hi_n;
   logic [WIDTH-1:0]   div_lo_n;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic               mul_exc;

   always_comb begin
      start = (ctrl_MULT | ctrl_DIV) & ~ctrl_flush & (state != RUN);
      a_neg = ctrl_SIGNED & data_operandA[WIDTH-1];
      b_neg = ctrl_SIGNED & data_operandB[WIDTH-1];
      a_mag = a_neg ? -data_operandA : data_operandA;
      b_mag = b_neg ? -data_operandB : data_operandB;

      // multiply: acc_hi gathers the sum, acc_lo shifts out multiplier bits
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

      // divide: acc_hi is the partial remainder, acc_lo dividend in / quotient out
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      div_ge    = ~div_diff[WIDTH];
      div_hi_n  = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

      prod    = {mul_hi_n, mul_lo_n};
      prod_s  = neg_q ? -prod : prod;
      mul_exc = op_signed ? ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]))
                          : |prod_s[2*WIDTH-1:WIDTH];
      quo_s   = neg_q ? -div_lo_n : div_lo_n;
      rem_s   = neg_r ? -div_hi_n : div_hi_n;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         busy           <= 1'b0;
         data_resultRDY <= 1'b0;
         data_result    <= '0;
         data_high      <= '0;
         data_exception <= 1'b0;
         op_div         <= 1'b0;
         op_signed      <= 1'b0;
         neg_q          <= 1'b0;
         neg_r          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         opnd           <= '0;
         acc_hi         <= '0;
         acc_lo         <= '0;
         dividend       <= '0;
      end else begin
         data_resultRDY <= 1'b0;
         if (ctrl_flush) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
         end else if (start) begin
            state     <= RUN;
            cnt       <= CNT_LOAD;
            busy      <= 1'b1;
            op_div    <= ~ctrl_MULT;
            op_signed <= ctrl_SIGNED;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            dividend  <= data_operandA;
            div_zero  <= ~(|data_operandB);
            div_ovf   <= ctrl_SIGNED & (data_operandA == MIN_VAL) & (&data_operandB);
            acc_hi    <= '0;
            opnd      <= ctrl_MULT ? a_mag : b_mag;
            acc_lo    <= ctrl_MULT ? b_mag : a_mag;
         end else begin
            case (state)
               RUN: begin
                  cnt    <= cnt - CNT_ONE;
                  acc_hi <= op_div ? div_hi_n : mul_hi_n;
                  acc_lo <= op_div ? div_lo_n : mul_lo_n;
                  if (cnt == CNT_ONE) begin
                     state          <= DONE;
                     busy           <= 1'b0;
                     data_resultRDY <= 1'b1;
                     if (!op_div) begin
                        data_result    <= prod_s[WIDTH-1:0];
                        data_high      <= prod_s[2*WIDTH-1:WIDTH];
                        data_exception <= mul_exc;
                     end else if (div_zero) begin
                        data_result    <= '0;
                        data_high      <= dividend;
                        data_exception <= 1'b1;
                     end else begin
                        data_result    <= quo_s;
                        data_high      <= rem_s;
                        data_exception <= div_ovf;
                     end
                  end
               end
               DONE:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
